// File: rtl/config_register_bank.sv
// Write responder with a 16 x 4-bit shadow bank and an active bank for the VGA pipeline.
// Shadow contents are committed on frame_start, or written straight through when IMMEDIATE is set.
module config_register_bank #(
  parameter int ACK_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic [3:0]  data,
  input  logic        valid,
  input  logic        frame_start,
  output logic        ack,
  output logic [63:0] active_regs,
  output logic        pending
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACK,
    HOLD
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'((ACK_DELAY >= 2) ? (ACK_DELAY - 2) : 0);

  generate
    if (ACK_DELAY < 1 || ACK_DELAY > 6) begin : g_bad_delay
      $error("config_register_bank: ACK_DELAY must be in 1..6");
    end
  endgenerate

  state_t     state;
  state_t     next_state;
  logic [2:0] cnt;
  logic [2:0] cnt_next;

  logic [3:0] shadow [16];
  logic [3:0] active [16];

  logic       ctrl_imm;
  logic       ctrl_lock;
  logic       wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      ack   <= (next_state == ACK);
    end
  end

  // A dropped valid in DELAY means the initiator timed out, so the request is abandoned.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (valid) begin
          if (ACK_DELAY > 1) next_state = DELAY;
          else               next_state = ACK;
        end
      end
      DELAY: begin
        if (!valid) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = ACK;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      ACK: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (!valid) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Control bits always come from the shadow copy of register 15, as it was before this write.
  always_comb begin
    ctrl_imm  = shadow[15][0];
    ctrl_lock = shadow[15][1];
    wr_en     = (state == ACK) && !(ctrl_lock && (address != 4'hF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_en) begin
      shadow[address] <= data;
    end
  end

  // The commit copies the shadow including any write landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        active[i] <= '0;
      end
      pending <= 1'b0;
    end else if (frame_start) begin
      for (int i = 0; i < 16; i++) begin
        if (wr_en && (address == 4'(i))) active[i] <= data;
        else                             active[i] <= shadow[i];
      end
      pending <= 1'b0;
    end else if (wr_en) begin
      if (ctrl_imm) active[address] <= data;
      else          pending         <= 1'b1;
    end
  end

  always_comb begin
    active_regs = '0;
    for (int i = 0; i < 16; i++) begin
      active_regs[4*i +: 4] = active[i];
    end
  end

endmodule

// File: tb/tb_config_register_bank.sv
// Directed bench for config_register_bank: three instances (ACK_DELAY 1, 6, 4) share the
// stimulus, one is selected at a time; expected values are hand-computed constants.
module tb_config_register_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  address;
  logic [3:0]  data;
  logic        valid;
  logic        frame_start;
  int          sel;

  logic        valid0, valid1, valid2;
  logic        ack0, ack1, ack2;
  logic        pending0, pending1, pending2;
  logic [63:0] active0, active1, active2;

  logic        ack_m;
  logic        pending_m;
  logic [63:0] active_m;

  int          checks;
  int          errors;

  config_register_bank #(.ACK_DELAY(1)) dut_d1 (
    .clk(clk), .rst(rst), .address(address), .data(data), .valid(valid0),
    .frame_start(frame_start), .ack(ack0), .active_regs(active0), .pending(pending0)
  );

  config_register_bank #(.ACK_DELAY(6)) dut_d6 (
    .clk(clk), .rst(rst), .address(address), .data(data), .valid(valid1),
    .frame_start(frame_start), .ack(ack1), .active_regs(active1), .pending(pending1)
  );

  config_register_bank #(.ACK_DELAY(4)) dut_d4 (
    .clk(clk), .rst(rst), .address(address), .data(data), .valid(valid2),
    .frame_start(frame_start), .ack(ack2), .active_regs(active2), .pending(pending2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    valid0    = valid && (sel == 0);
    valid1    = valid && (sel == 1);
    valid2    = valid && (sel == 2);
    ack_m     = ack0;
    pending_m = pending0;
    active_m  = active0;
    if (sel == 1) begin
      ack_m     = ack1;
      pending_m = pending1;
      active_m  = active1;
    end else if (sel == 2) begin
      ack_m     = ack2;
      pending_m = pending2;
      active_m  = active2;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b1;
    valid       = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic frameStrobe();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Holds valid for 'hold' cycles, records the first ack cycle and total acks seen,
  // optionally pulses frame_start in the ack cycle, then lets the FSM settle.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] d, input int hold,
                               input bit fs, output int ack_cycle, output int ack_count);
    ack_cycle = 0;
    ack_count = 0;
    @(negedge clk);
    address = a;
    data    = d;
    valid   = 1'b1;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (ack_m) begin
        ack_count++;
        if (ack_cycle == 0) begin
          ack_cycle   = c;
          frame_start = fs;
        end
      end
    end
    valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (ack_m) ack_count++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ac;
    int an;
    int seen;
    checks      = 0;
    errors      = 0;
    sel         = 0;
    rst         = 1'b1;
    address     = '0;
    data        = '0;
    valid       = 1'b0;
    frame_start = 1'b0;

    // ACK_DELAY = 1
    sel = 0;
    doReset();
    checkOutput("reset_ack", {63'd0, ack_m}, 64'd0);
    checkOutput("reset_pending", {63'd0, pending_m}, 64'd0);
    checkOutput("reset_active", active_m, 64'h0);

    applyStimulus(4'h3, 4'hA, 1, 1'b0, ac, an);
    checkOutput("d1_ack_cycle", 64'(ac), 64'd1);
    checkOutput("d1_ack_count", 64'(an), 64'd1);
    checkOutput("d1_pending_set", {63'd0, pending_m}, 64'd1);
    checkOutput("d1_active_before", active_m, 64'h0);
    frameStrobe();
    checkOutput("d1_commit_active", active_m, 64'h0000_0000_0000_A000);
    checkOutput("d1_commit_pending", {63'd0, pending_m}, 64'd0);

    applyStimulus(4'hF, 4'h1, 1, 1'b0, ac, an);
    checkOutput("imm_ctrl_pending", {63'd0, pending_m}, 64'd1);
    frameStrobe();
    checkOutput("imm_ctrl_active", active_m, 64'h1000_0000_0000_A000);
    applyStimulus(4'h0, 4'h5, 1, 1'b0, ac, an);
    checkOutput("imm_write_active", active_m, 64'h1000_0000_0000_A005);
    checkOutput("imm_write_pending", {63'd0, pending_m}, 64'd0);

    applyStimulus(4'hF, 4'h2, 1, 1'b0, ac, an);
    checkOutput("lock_set_active", active_m, 64'h2000_0000_0000_A005);
    applyStimulus(4'h7, 4'hF, 1, 1'b0, ac, an);
    checkOutput("lock_ack_count", 64'(an), 64'd1);
    checkOutput("lock_active", active_m, 64'h2000_0000_0000_A005);
    checkOutput("lock_pending", {63'd0, pending_m}, 64'd0);
    frameStrobe();
    checkOutput("lock_shadow_kept", active_m, 64'h2000_0000_0000_A005);
    applyStimulus(4'hF, 4'h0, 1, 1'b0, ac, an);
    checkOutput("unlock_ack_count", 64'(an), 64'd1);
    checkOutput("unlock_pending", {63'd0, pending_m}, 64'd1);
    applyStimulus(4'h7, 4'hF, 1, 1'b0, ac, an);
    frameStrobe();
    checkOutput("unlock_commit", active_m, 64'h0000_0000_F000_A005);
    checkOutput("unlock_commit_pend", {63'd0, pending_m}, 64'd0);

    // ACK_DELAY = 6
    sel = 1;
    doReset();
    applyStimulus(4'h2, 4'h3, 8, 1'b0, ac, an);
    checkOutput("d6_ack_cycle", 64'(ac), 64'd6);
    checkOutput("d6_ack_count", 64'(an), 64'd1);
    applyStimulus(4'h4, 4'h9, 8, 1'b0, ac, an);
    checkOutput("d6_rearm_cycle", 64'(ac), 64'd6);
    checkOutput("d6_rearm_count", 64'(an), 64'd1);
    checkOutput("d6_pending", {63'd0, pending_m}, 64'd1);
    checkOutput("d6_active_before", active_m, 64'h0);
    applyStimulus(4'h5, 4'hC, 6, 1'b1, ac, an);
    checkOutput("fs_coincident_cycle", 64'(ac), 64'd6);
    checkOutput("fs_coincident_active", active_m, 64'h0000_0000_00C9_0300);
    checkOutput("fs_coincident_pend", {63'd0, pending_m}, 64'd0);

    @(negedge clk);
    address = 4'h1;
    data    = 4'h7;
    valid   = 1'b1;
    seen    = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_m) seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (ack_m) seen++;
    checkOutput("rst_mid_ack_count", 64'(seen), 64'd0);
    checkOutput("rst_mid_active", active_m, 64'h0);
    checkOutput("rst_mid_pending", {63'd0, pending_m}, 64'd0);
    rst = 1'b0;
    ac  = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ack_m && ac == 0) ac = c;
    end
    valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_release_cycle", 64'(ac), 64'd6);
    checkOutput("rst_release_pending", {63'd0, pending_m}, 64'd1);
    checkOutput("rst_release_active", active_m, 64'h0);

    // ACK_DELAY = 4
    sel = 2;
    doReset();
    applyStimulus(4'h6, 4'hB, 2, 1'b0, ac, an);
    checkOutput("abandon_ack_count", 64'(an), 64'd0);
    checkOutput("abandon_pending", {63'd0, pending_m}, 64'd0);
    frameStrobe();
    checkOutput("abandon_no_write", active_m, 64'h0);
    applyStimulus(4'h6, 4'hB, 4, 1'b0, ac, an);
    checkOutput("d4_ack_cycle", 64'(ac), 64'd4);
    checkOutput("d4_ack_count", 64'(an), 64'd1);
    checkOutput("d4_pending", {63'd0, pending_m}, 64'd1);
    frameStrobe();
    checkOutput("d4_commit", active_m, 64'h0000_0000_0B00_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_register_bank.md
# config_register_bank

Responder end of the address/data/valid/ack write interface. It accepts 4-bit address + 4-bit data write requests from the frame-splitting front end and acknowledges each one with a single-cycle ack. Writes land in a 16 x 4-bit shadow register bank. The shadow bank is copied to the active bank that drives the VGA pipeline either at the next frame boundary or immediately, as selected by software.

## Interface
- ACK_DELAY, 1, cycles from request acceptance to ack assertion; legal range 1..6 so ack always lands inside the initiator's 8-cycle timeout window.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- address  input  4  register index of the write request; stable while valid is high
- data  input  4  write value; stable while valid is high
- valid  input  1  write request from the initiator; level, held until ack or initiator timeout
- frame_start  input  1  single-cycle pulse at start of each video frame (vsync boundary)
- ack  output  1  single-cycle acknowledge of an accepted write
- active_regs  output  64  active bank; register n on bits [4n+3:4n]
- pending  output  1  high when the shadow bank differs from the active bank (uncommitted writes exist)

## Operation
- Register 15 is the control register:
  - bit0 IMMEDIATE: writes also update the active bank in the same edge.
  - bit1 LOCK: writes to registers 0..14 are acked but discarded.
  - bits 3:2 are stored and have no function.
- Register 15 is always writable, including while LOCK=1. It is part of both banks; its control bits are taken from the shadow copy.
- FSM states and transitions:
  - IDLE: valid=1 moves to DELAY when ACK_DELAY>1, or directly to ACK when ACK_DELAY=1. The delay counter is loaded with 0.
  - DELAY: the counter increments each cycle. When the counter reaches ACK_DELAY-2, the FSM moves to ACK.
  - ACK: ack=1 for exactly this cycle; the write takes effect; the FSM moves to HOLD.
  - HOLD: the FSM waits for valid=0, then returns to IDLE. A valid held high is never treated as a second request.
- If valid drops during DELAY (initiator timed out), the request is abandoned: no write, no ack, and the FSM returns to IDLE.
- Write effect in ACK:
  - Shadow[address] gets data unless LOCK=1 and address<15.
  - If IMMEDIATE=1 (the shadow value before this write), the same update is applied to the active bank.
- Commit: on a cycle with frame_start=1, the active bank gets the full shadow bank, including any write taking effect in that same cycle, and pending clears.
- pending rules:
  - Set by any write that modifies the shadow without also modifying the active bank.
  - A write in the same cycle as frame_start leaves pending=0.
  - Discarded (locked) writes do not set pending.

## Timing
- Reset values: ack=0, pending=0, active_regs=64'h0, shadow=0, state IDLE, counter 0.
- Reset mid-transaction: the FSM returns to IDLE immediately, with no ack and no write. After release, a still-high valid is accepted as a new request.
- Latency: valid first sampled high at edge T → ack high during cycle T+ACK_DELAY. The shadow and active registers are updated at the edge that ends the ack cycle.
- ack is registered, is never high for two consecutive cycles, and is never high in IDLE, DELAY or HOLD.
- Minimum spacing between requests is ACK_DELAY+2 cycles (ACK, HOLD, IDLE).
- frame_start is handled in any FSM state and is independent of the handshake.
- active_regs and pending are registered outputs, with no combinational path from inputs.

## Test plan
- Reset, ACK_DELAY=1: valid=1, address=4'h3, data=4'hA → ack high exactly one cycle, one cycle after acceptance; pending=1; active_regs[15:12]=0. frame_start pulse → active_regs[15:12]=4'hA, pending=0.
- ACK_DELAY=6: valid held 8 cycles → ack in cycle 6 only. With valid held high after ack, no further ack appears until valid goes low and then high again.
- Write reg15=4'h1, then address=4'h0, data=4'h5 → active_regs[3:0]=4'h5 directly after the ack cycle, with pending=0.
- Write reg15=4'h2, then address=4'h7, data=4'hF → ack asserted, shadow and active reg7 stay 0, pending unchanged. Then write reg15=4'h0 → accepted and lock released.
- ACK_DELAY=4: valid drops after 2 cycles → no ack, no write, FSM back to IDLE. A following request is acked normally.
- Write with ack cycle coincident with frame_start → active bank has the new value after that edge; pending=0. Assert rst during DELAY → ack never asserts, all outputs return to 0.
